// File: rtl/write_checker_pkg.sv
// Shared types and helpers for the store monitor: FSM states, fail reason codes,
// and the index-width rule used by every file that sizes a table index.
package write_checker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_TIMEOUT  = 2'd1,
      FC_MISMATCH = 2'd2,
      FC_ORDER    = 2'd3
   } fail_code_t;

   // A one-entry table still needs a 1-bit index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/write_checker_if.sv
// Bundles the expectation-load port, the snooped store port and the status outputs
// of write_checker; master drives stimulus, slave is the checker itself.
interface write_checker_if
   import write_checker_pkg::*;
#(
   parameter int N       = 16,
   parameter int A       = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024
) ();
   localparam int IW = idx_width(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic          exp_we;
   logic [IW-1:0] exp_idx;
   logic [A-1:0]  exp_addr;
   logic [N-1:0]  exp_data;
   logic [IW:0]   num_exp;
   logic          start;
   logic          memwrite;
   logic [A-1:0]  dataadr;
   logic [N-1:0]  writedata;
   logic          busy;
   logic          done;
   logic          pass;
   logic          fail;
   logic [1:0]    fail_code;
   logic [IW:0]   match_count;
   logic [CW-1:0] cycles;

   modport master (
      output exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
             memwrite, dataadr, writedata,
      input  busy, done, pass, fail, fail_code, match_count, cycles
   );

   modport slave (
      input  exp_we, exp_idx, exp_addr, exp_data, num_exp, start,
             memwrite, dataadr, writedata,
      output busy, done, pass, fail, fail_code, match_count, cycles
   );
endinterface

// File: rtl/write_checker_exp_table.sv
// Expectation table: DEPTH address/data/matched entries with per-entry compare
// against the snooped store; entries at or beyond num do not participate.
module write_checker_exp_table
   import write_checker_pkg::*;
#(
   parameter int N     = 16,
   parameter int A     = 16,
   parameter int DEPTH = 4,
   parameter int IW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IW-1:0]    widx,
   input  logic [A-1:0]     waddr,
   input  logic [N-1:0]     wdata,
   input  logic             clr_matched,
   input  logic             set_matched,
   input  logic [IW-1:0]    set_idx,
   input  logic [IW:0]      num,
   input  logic [A-1:0]     snoop_addr,
   input  logic [N-1:0]     snoop_data,
   output logic [DEPTH-1:0] addr_hit,
   output logic [DEPTH-1:0] full_hit,
   output logic [DEPTH-1:0] matched
);
   logic [A-1:0]     addr_reg [DEPTH];
   logic [N-1:0]     data_reg [DEPTH];
   logic [DEPTH-1:0] matched_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_reg[i] <= '0;
            data_reg[i] <= '0;
         end
         matched_reg <= '0;
      end else begin
         if (we) begin
            addr_reg[widx] <= waddr;
            data_reg[widx] <= wdata;
         end
         if (clr_matched) begin
            matched_reg <= '0;
         end else if (set_matched) begin
            matched_reg[set_idx] <= 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      logic valid;
      assign valid        = ((IW+1)'(gi) < num);
      assign addr_hit[gi] = valid && (addr_reg[gi] == snoop_addr);
      assign full_hit[gi] = addr_hit[gi] && (data_reg[gi] == snoop_data);
   end

   assign matched = matched_reg;

endmodule

// File: rtl/write_checker.sv
// Store monitor: arms on start, matches snooped stores against the expectation
// table in ordered or unordered mode, and ends sticky in PASS or FAIL.
module write_checker
   import write_checker_pkg::*;
#(
   parameter int N       = 16,
   parameter int A       = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int ORDERED = 1
) (
   input logic            clk,
   input logic            reset,
   write_checker_if.slave bus
);
   localparam int IW = idx_width(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t           state_reg, state_next;
   fail_code_t       fail_code_reg, fail_code_next;
   logic [IW:0]      num_reg, num_next;
   logic [IW:0]      match_count_reg, match_count_next;
   logic [CW-1:0]    cycles_reg, cycles_next;

   logic [DEPTH-1:0] addr_hit, full_hit, matched, free_hit, above_ptr;
   logic [IW-1:0]    ptr, low_idx, hit_idx;
   logic             hit, table_we, clr_matched, set_matched;
   fail_code_t       bad;

   write_checker_exp_table #(
      .N(N), .A(A), .DEPTH(DEPTH), .IW(IW)
   ) u_table (
      .clk        (clk),
      .reset      (reset),
      .we         (table_we),
      .widx       (bus.exp_idx),
      .waddr      (bus.exp_addr),
      .wdata      (bus.exp_data),
      .clr_matched(clr_matched),
      .set_matched(set_matched),
      .set_idx    (hit_idx),
      .num        (num_reg),
      .snoop_addr (bus.dataadr),
      .snoop_data (bus.writedata),
      .addr_hit   (addr_hit),
      .full_hit   (full_hit),
      .matched    (matched)
   );

   // In ordered mode the next entry to satisfy is always entry match_count.
   assign ptr      = match_count_reg[IW-1:0];
   assign free_hit = full_hit & ~matched;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_above
      assign above_ptr[gi] = (IW'(gi) > ptr);
   end

   always_comb begin
      low_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (free_hit[i]) low_idx = IW'(i);
      end
   end

   // Classify the current store, ignoring the strobe; the FSM gates on memwrite.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      bad     = FC_NONE;
      if (ORDERED != 0) begin
         if (addr_hit[ptr]) begin
            if (full_hit[ptr]) begin
               hit     = 1'b1;
               hit_idx = ptr;
            end else begin
               bad = FC_MISMATCH;
            end
         end else if (|(free_hit & above_ptr)) begin
            bad = FC_ORDER;
         end
      end else begin
         if (|free_hit) begin
            hit     = 1'b1;
            hit_idx = low_idx;
         end else if (|(addr_hit & ~matched)) begin
            bad = FC_MISMATCH;
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      fail_code_next   = fail_code_reg;
      num_next         = num_reg;
      match_count_next = match_count_reg;
      cycles_next      = cycles_reg;
      table_we         = 1'b0;
      clr_matched      = 1'b0;
      set_matched      = 1'b0;
      case (state_reg)
         RUN: begin
            cycles_next = (cycles_reg == '1) ? cycles_reg : cycles_reg + 1'b1;
            if (bus.memwrite && hit) begin
               set_matched      = 1'b1;
               match_count_next = match_count_reg + 1'b1;
            end
            // Completion beats a bad store, which beats the timeout.
            if ((num_reg == '0) || (bus.memwrite && hit && (match_count_next == num_reg))) begin
               state_next = PASS;
            end else if (bus.memwrite && (bad != FC_NONE)) begin
               state_next     = FAIL;
               fail_code_next = bad;
            end else if (cycles_next == CW'(TIMEOUT - 1)) begin
               state_next     = FAIL;
               fail_code_next = FC_TIMEOUT;
            end
         end
         default: begin
            table_we = bus.exp_we;
            if (bus.start) begin
               clr_matched      = 1'b1;
               match_count_next = '0;
               cycles_next      = '0;
               fail_code_next   = FC_NONE;
               num_next         = bus.num_exp;
               state_next       = RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         fail_code_reg   <= FC_NONE;
         num_reg         <= '0;
         match_count_reg <= '0;
         cycles_reg      <= '0;
      end else begin
         state_reg       <= state_next;
         fail_code_reg   <= fail_code_next;
         num_reg         <= num_next;
         match_count_reg <= match_count_next;
         cycles_reg      <= cycles_next;
      end
   end

   assign bus.busy        = (state_reg == RUN);
   assign bus.done        = (state_reg == PASS) || (state_reg == FAIL);
   assign bus.pass        = (state_reg == PASS);
   assign bus.fail        = (state_reg == FAIL);
   assign bus.fail_code   = fail_code_reg;
   assign bus.match_count = match_count_reg;
   assign bus.cycles      = cycles_reg;

endmodule

// File: tb/tb_write_checker.sv
// Drives an ordered and an unordered checker with identical stimulus and checks
// both against a table-level model plus hand-derived directed expectations.
module tb_write_checker;
   import write_checker_pkg::*;

   localparam int TO      = 16;
   localparam int CYC_MAX = 31;

   logic        clk = 1'b0;
   logic        reset;
   logic        exp_we;
   logic [1:0]  exp_idx;
   logic [15:0] exp_addr, exp_data;
   logic [2:0]  num_exp;
   logic        start, memwrite;
   logic [15:0] dataadr, writedata;
   bit          verbose;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   write_checker_if #(.N(16), .A(16), .DEPTH(4), .TIMEOUT(TO)) ord_bus ();
   write_checker_if #(.N(16), .A(16), .DEPTH(4), .TIMEOUT(TO)) unord_bus ();

   assign ord_bus.exp_we    = exp_we;    assign unord_bus.exp_we    = exp_we;
   assign ord_bus.exp_idx   = exp_idx;   assign unord_bus.exp_idx   = exp_idx;
   assign ord_bus.exp_addr  = exp_addr;  assign unord_bus.exp_addr  = exp_addr;
   assign ord_bus.exp_data  = exp_data;  assign unord_bus.exp_data  = exp_data;
   assign ord_bus.num_exp   = num_exp;   assign unord_bus.num_exp   = num_exp;
   assign ord_bus.start     = start;     assign unord_bus.start     = start;
   assign ord_bus.memwrite  = memwrite;  assign unord_bus.memwrite  = memwrite;
   assign ord_bus.dataadr   = dataadr;   assign unord_bus.dataadr   = dataadr;
   assign ord_bus.writedata = writedata; assign unord_bus.writedata = writedata;

   write_checker #(.N(16), .A(16), .DEPTH(4), .TIMEOUT(TO), .ORDERED(1)) dut_ord (
      .clk(clk), .reset(reset), .bus(ord_bus)
   );
   write_checker #(.N(16), .A(16), .DEPTH(4), .TIMEOUT(TO), .ORDERED(0)) dut_unord (
      .clk(clk), .reset(reset), .bus(unord_bus)
   );

   // Reference model, index 0 = ordered checker, 1 = unordered checker.
   // m_state: 0 idle, 1 running, 2 passed, 3 failed.
   int          m_state [2];
   logic [15:0] m_addr  [2][4];
   logic [15:0] m_data  [2][4];
   bit          m_done_e[2][4];
   int          m_count [2];
   int          m_cycles[2];
   int          m_code  [2];
   int          m_num   [2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got === req) passed++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_state[m] = 0; m_count[m] = 0; m_cycles[m] = 0; m_code[m] = 0; m_num[m] = 0;
         for (int j = 0; j < 4; j++) begin
            m_addr[m][j] = '0; m_data[m][j] = '0; m_done_e[m][j] = 1'b0;
         end
      end
   endtask

   // One clock edge worth of behaviour, computed from the checking rules directly.
   task automatic model_step(input int m);
      int cyc, hit, bad;
      bit any_addr;
      if (m_state[m] != 1) begin
         if (exp_we) begin
            m_addr[m][exp_idx] = exp_addr;
            m_data[m][exp_idx] = exp_data;
         end
         if (start) begin
            for (int j = 0; j < 4; j++) m_done_e[m][j] = 1'b0;
            m_count[m] = 0; m_cycles[m] = 0; m_code[m] = 0;
            m_num[m] = int'(num_exp); m_state[m] = 1;
         end
      end else begin
         cyc = (m_cycles[m] < CYC_MAX) ? m_cycles[m] + 1 : CYC_MAX;
         hit = -1; bad = 0; any_addr = 1'b0;
         if (memwrite && m_count[m] < m_num[m]) begin
            if (m == 0) begin
               if (dataadr == m_addr[m][m_count[m]]) begin
                  if (writedata == m_data[m][m_count[m]]) hit = m_count[m];
                  else bad = 2;
               end else begin
                  for (int j = m_count[m] + 1; j < m_num[m]; j++)
                     if (!m_done_e[m][j] && dataadr == m_addr[m][j] && writedata == m_data[m][j]) bad = 3;
               end
            end else begin
               for (int j = 0; j < m_num[m]; j++) begin
                  if (!m_done_e[m][j] && dataadr == m_addr[m][j]) begin
                     if (writedata == m_data[m][j] && hit < 0) hit = j;
                     else any_addr = 1'b1;
                  end
               end
               if (hit < 0 && any_addr) bad = 2;
            end
         end
         if (hit >= 0) begin
            m_done_e[m][hit] = 1'b1;
            m_count[m]++;
         end
         if (m_num[m] == 0 || (hit >= 0 && m_count[m] == m_num[m])) m_state[m] = 2;
         else if (bad != 0) begin m_state[m] = 3; m_code[m] = bad; end
         else if (cyc == TO - 1) begin m_state[m] = 3; m_code[m] = 1; end
         m_cycles[m] = cyc;
      end
   endtask

   function automatic logic [13:0] model_status(input int m);
      return {m_state[m] == 1, m_state[m] >= 2, m_state[m] == 2, m_state[m] == 3,
              2'(m_code[m]), 3'(m_count[m]), 5'(m_cycles[m])};
   endfunction

   function automatic logic [13:0] dut_status(input int m);
      if (m == 0)
         return {ord_bus.busy, ord_bus.done, ord_bus.pass, ord_bus.fail,
                 ord_bus.fail_code, ord_bus.match_count, ord_bus.cycles};
      return {unord_bus.busy, unord_bus.done, unord_bus.pass, unord_bus.fail,
              unord_bus.fail_code, unord_bus.match_count, unord_bus.cycles};
   endfunction

   task automatic tick(input logic we, input logic [1:0] idx, input logic [15:0] ea, input logic [15:0] ed,
                       input logic [2:0] num, input logic st, input logic mw,
                       input logic [15:0] ad, input logic [15:0] wd);
      exp_we = we; exp_idx = idx; exp_addr = ea; exp_data = ed; num_exp = num;
      start = st; memwrite = mw; dataadr = ad; writedata = wd;
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      check("model_ord", 32'(dut_status(0)), 32'(model_status(0)));
      check("model_unord", 32'(dut_status(1)), 32'(model_status(1)));
      if (verbose)
         $display("txn we=%b st=%b mw=%b %h:%h | ord status=%h | unord status=%h",
                  we, st, mw, ad, wd, dut_status(0), dut_status(1));
   endtask

   task automatic idle();
      tick(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic store(input logic [15:0] ad, input logic [15:0] wd);
      tick(1'b0, 2'd0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b1, ad, wd);
   endtask

   task automatic arm(input logic [2:0] num);
      tick(1'b0, 2'd0, 16'h0, 16'h0, num, 1'b1, 1'b0, 16'h0, 16'h0);
   endtask

   // Hand-derived flag check: {busy, pass, fail, fail_code, match_count}.
   task automatic hand(input string name, input int m, input logic busy, input logic pass,
                       input logic fail, input logic [1:0] code, input logic [2:0] mc);
      logic [7:0] got;
      got = (m == 0) ? {ord_bus.busy, ord_bus.pass, ord_bus.fail, ord_bus.fail_code, ord_bus.match_count}
                     : {unord_bus.busy, unord_bus.pass, unord_bus.fail, unord_bus.fail_code, unord_bus.match_count};
      check(name, 32'(got), 32'({busy, pass, fail, code, mc}));
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  idx;
      logic [15:0] ea, ed;
      logic [2:0]  num;
      logic        st, mw;
      logic [15:0] ad, wd;
      logic [1:0]  chk;
      logic        e_busy, e_pass, e_fail;
      logic [1:0]  e_code;
      logic [2:0]  e_mc;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] idx, input logic [15:0] ea, input logic [15:0] ed,
                               input logic [2:0] num, input logic st, input logic mw,
                               input logic [15:0] ad, input logic [15:0] wd, input logic [1:0] chk,
                               input logic eb, input logic ep, input logic ef,
                               input logic [1:0] ec, input logic [2:0] emc);
      vec_t v;
      v.we = we; v.idx = idx; v.ea = ea; v.ed = ed; v.num = num; v.st = st; v.mw = mw;
      v.ad = ad; v.wd = wd; v.chk = chk; v.e_busy = eb; v.e_pass = ep; v.e_fail = ef;
      v.e_code = ec; v.e_mc = emc;
      return v;
   endfunction

   vec_t vecs [11];

   initial begin
      //            we idx  ea        ed        num st mw  ad        wd       chk b  p  f  code mc
      vecs[0]  = mk(1, 0, 16'h0084, 16'h0096, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 1, 16'h0088, 16'h0007, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 16'h0000, 16'h0000, 2, 1, 0, 16'h0000, 16'h0000, 3, 1, 0, 0, 0, 0);
      vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0080, 16'h1234, 3, 1, 0, 0, 0, 0);
      vecs[4]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0084, 16'h0096, 3, 1, 0, 0, 0, 1);
      vecs[5]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0088, 16'h0007, 3, 0, 1, 0, 0, 2);
      vecs[6]  = mk(0, 0, 16'h0000, 16'h0000, 2, 1, 0, 16'h0000, 16'h0000, 3, 1, 0, 0, 0, 0);
      vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0088, 16'h0007, 1, 0, 0, 1, 3, 0);
      vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0084, 16'h0096, 2, 0, 1, 0, 0, 2);
      vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 2, 1, 0, 16'h0000, 16'h0000, 3, 1, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0084, 16'h0095, 3, 0, 0, 1, 2, 0);

      verbose = 1'b1;
      reset = 1'b1;
      exp_we = 0; exp_idx = 0; exp_addr = 0; exp_data = 0; num_exp = 0;
      start = 0; memwrite = 0; dataadr = 0; writedata = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset_ord", 32'(dut_status(0)), 32'd0);
      check("reset_unord", 32'(dut_status(1)), 32'd0);
      reset = 1'b0;

      // Directed table: ordered/unordered pass, order fail, data mismatch.
      for (int i = 0; i < 11; i++) begin
         tick(vecs[i].we, vecs[i].idx, vecs[i].ea, vecs[i].ed, vecs[i].num,
              vecs[i].st, vecs[i].mw, vecs[i].ad, vecs[i].wd);
         for (int m = 0; m < 2; m++)
            if (vecs[i].chk[m])
               hand($sformatf("vec%0d_dut%0d", i, m), m, vecs[i].e_busy, vecs[i].e_pass,
                    vecs[i].e_fail, vecs[i].e_code, vecs[i].e_mc);
         if (i == 5) check("pass_cycles", 32'(ord_bus.cycles), 32'd3);
      end

      // Timeout with no matching store: fails as cycles reaches TO-1.
      arm(3'd1);
      for (int k = 0; k < TO - 2; k++) idle();
      hand("pre_timeout_ord", 0, 1, 0, 0, 0, 0);
      check("pre_timeout_cycles", 32'(ord_bus.cycles), 32'(TO - 2));
      idle();
      hand("timeout_ord", 0, 0, 0, 1, 1, 0);
      hand("timeout_unord", 1, 0, 0, 1, 1, 0);
      check("timeout_cycles", 32'(unord_bus.cycles), 32'(TO - 1));

      // Completing store on the timeout edge wins.
      arm(3'd1);
      for (int k = 0; k < TO - 2; k++) idle();
      store(16'h0084, 16'h0096);
      hand("edge_pass_ord", 0, 0, 1, 0, 0, 1);
      hand("edge_pass_unord", 1, 0, 1, 0, 0, 1);
      check("edge_pass_cycles", 32'(ord_bus.cycles), 32'(TO - 1));

      // Reset mid-run, between clock edges.
      arm(3'd2);
      store(16'h0084, 16'h0096);
      hand("pre_reset_ord", 0, 1, 0, 0, 0, 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_ord", 32'(dut_status(0)), 32'd0);
      check("async_reset_unord", 32'(dut_status(1)), 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Cleared table: entry 0 now expects address 0, data 0.
      arm(3'd1);
      store(16'h0000, 16'h0000);
      hand("cleared_entry_ord", 0, 0, 1, 0, 0, 1);
      tick(1'b1, 2'd0, 16'h0084, 16'h0096, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0);
      arm(3'd0);
      hand("zero_exp_armed", 0, 1, 0, 0, 0, 0);
      idle();
      hand("zero_exp_pass_ord", 0, 0, 1, 0, 0, 0);
      hand("zero_exp_pass_unord", 1, 0, 1, 0, 0, 0);

      // Randomised traffic over a small address/data alphabet.
      verbose = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         tick($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
              16'h0080 + 16'(4 * $urandom_range(0, 3)), 16'($urandom_range(0, 3)),
              3'($urandom_range(0, 4)), $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
              16'h0080 + 16'(4 * $urandom_range(0, 4)), 16'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/write_checker.md
Name: write_checker

Overview:
- Synthesisable, self-checking store monitor for the 16-bit single-cycle computer; bench-side today, reusable as an on-chip test harness later.
- Snoops the data-memory write port (memwrite, dataadr, writedata) and compares observed stores against a loaded table of up to DEPTH expected address/data pairs.
- Supports ordered or unordered matching and a cycle timeout.
- Reports pass/fail with a reason code, replacing hard-coded single-address checks in benches.

Parameters:
- N, 16, data width of writedata and exp_data
- A, 16, address width of dataadr and exp_addr
- DEPTH, 4, number of expectation entries (>=1)
- TIMEOUT, 1024, cycles in RUN before timeout fail (>=2)
- ORDERED, 1, 1 = expectations must be met in index order; 0 = any order
- IW, $clog2(DEPTH) (min 1), derived index width
- CW, $clog2(TIMEOUT+1), derived cycle-counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- exp_we  in  1  write one expectation entry; honoured only when state != RUN
- exp_idx  in  IW  entry index for exp_we
- exp_addr  in  A  expected store address
- exp_data  in  N  expected store data
- num_exp  in  IW+1  number of valid entries (0..DEPTH); sampled on start
- start  in  1  arm and begin checking; single-cycle pulse
- memwrite  in  1  snooped store strobe
- dataadr  in  A  snooped store address
- writedata  in  N  snooped store data
- busy  out  1  state == RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state == PASS
- fail  out  1  state == FAIL
- fail_code  out  2  0 none, 1 timeout, 2 data mismatch, 3 out of order
- match_count  out  IW+1  entries matched so far
- cycles  out  CW  cycles spent in RUN

Behaviour:
- Reset (async): state IDLE; table addr/data/matched cleared to 0; busy, done, pass, fail, fail_code, match_count and cycles all 0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL:
  - exp_we writes entry exp_idx at the clock edge.
  - start clears matched bits, match_count, cycles and fail_code, latches num_exp, and enters RUN.
  - If the latched num_exp is 0, go to PASS on the next edge instead.
- RUN:
  - start and exp_we are ignored.
  - cycles increments every clock edge; it saturates, it does not wrap.
  - Only entries with idx < latched num_exp participate.
- Ordered mode (ORDERED=1), pointer ptr = match_count, evaluated on memwrite:
  - dataadr==addr[ptr] and writedata==data[ptr]: mark matched, match_count+1.
  - dataadr==addr[ptr], data differs: FAIL, code 2.
  - dataadr matches addr[j], j>ptr, unmatched, and data matches: FAIL, code 3.
  - Any other address: ignored. Program may freely store elsewhere.
- Unordered mode (ORDERED=0), evaluated on memwrite:
  - Lowest-index unmatched entry with addr and data equal is marked matched; match_count+1.
  - If some unmatched entry has an equal addr but none has equal addr and data: FAIL, code 2.
  - Writes to already-matched-only or unknown addresses are ignored.
- Completion: when the match that occurs makes match_count == num_exp, go to PASS on that same edge.
- Timeout: if cycles reaches TIMEOUT-1 on an edge without completion: FAIL, code 1.
- Priority on the same edge: completion > mismatch/order fail > timeout.
- Outputs are registered: state-derived flags become visible one edge after the triggering event.
- PASS/FAIL are sticky until start or reset; match_count and cycles hold their values.
- Reset mid-RUN aborts immediately: IDLE, table cleared.

Decomposition:
- Package write_checker_pkg: state_t enum (IDLE, RUN, PASS, FAIL) and fail_code_t enum (FC_NONE=0, FC_TIMEOUT=1, FC_MISMATCH=2, FC_ORDER=3).
- Sub-module exp_table:
  - Holds DEPTH entries of addr/data/matched.
  - Write port for load; set-matched port; clear-all.
  - Combinational compare vectors addr_hit[DEPTH] and full_hit[DEPTH], masked by num_exp.
  - FSM, counters and priority logic stay in write_checker.

Test Plan:
- Ordered, DEPTH=4, num_exp=2: load {84:0x0096, 88:0x0007}; start; stores 80:0x1234, 84:0x0096, 88:0x0007 -> match_count 1 then 2; pass=1, fail_code 0, cycles = edges spent in RUN.
- Ordered, same table: store 88:0x0007 before 84 -> fail=1, fail_code 3, match_count 0.
- Unordered, same table: stores 88:0x0007 then 84:0x0096 -> pass=1; then 84:0x0095 in a fresh run -> fail, code 2.
- TIMEOUT=16, num_exp=1, no matching store -> fail at cycles=15, code 1.
- Completion store lands on the timeout edge -> pass=1, code 0.
- Assert reset during RUN after 1 match -> all outputs 0 asynchronously; reload table and start, and num_exp=0 -> pass next edge.
